// File: rtl/display_pkg.sv
// Shared types and record layout for the display declaration classifier.
package display_pkg;

  localparam int unsigned REC_W    = 59;
  localparam int unsigned PROP_W   = 8;
  localparam int unsigned TYPE_W   = 4;
  localparam int unsigned VAL_W    = 47;
  localparam int unsigned PROP_MSB = 58;
  localparam int unsigned TYPE_MSB = 50;
  localparam int unsigned VAL_MSB  = 46;

  localparam logic [PROP_W-1:0] DEFAULT_DISPLAY_PROP_ID = 8'h1D;

  typedef enum logic [TYPE_W-1:0] {
    VT_KEYWORD  = 4'd0,
    VT_LENGTH   = 4'd1,
    VT_NUMBER   = 4'd2,
    VT_COLOR    = 4'd3,
    VT_PERCENT  = 4'd4,
    VT_FUNCTION = 4'd5,
    VT_LIST     = 4'd6,
    VT_INHERIT  = 4'd7,
    VT_INITIAL  = 4'd8
  } value_type_e;

  typedef struct packed {
    logic [PROP_MSB:TYPE_MSB+1] prop_id;
    logic [TYPE_MSB:VAL_MSB+1]  value_type;
    logic [VAL_MSB:0]           value;
  } display_rec_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EMIT  = 2'd2
  } state_e;

endpackage

// File: rtl/display_decl_classifier_if.sv
// Declaration input channel and parent-record fetch channel.
interface display_decl_classifier_if;

  logic                               decl_valid;
  logic                               decl_ready;
  logic [display_pkg::PROP_W-1:0]     decl_prop_id;
  logic [display_pkg::TYPE_W-1:0]     decl_value_type;
  logic [display_pkg::VAL_W-1:0]      decl_value;
  logic                               parent_req;
  logic                               parent_ack;
  logic [display_pkg::REC_W-1:0]      parent_value;

  modport master (
    output decl_valid, decl_prop_id, decl_value_type, decl_value,
    input  decl_ready,
    input  parent_req,
    output parent_ack, parent_value
  );

  modport slave (
    input  decl_valid, decl_prop_id, decl_value_type, decl_value,
    output decl_ready,
    output parent_req,
    input  parent_ack, parent_value
  );

endinterface

// File: rtl/display_decl_classify.sv
// Combinational qualifiers for a packed display record.
module display_decl_classify
  import display_pkg::*;
#(
  parameter logic [PROP_W-1:0] DISPLAY_PROP_ID = DEFAULT_DISPLAY_PROP_ID,
  parameter int unsigned       N_DISPLAY_KW    = 20
) (
  input  display_rec_t rec,
  output logic         is_primitive_c,
  output logic         is_valid_display_c
);

  always_comb begin
    is_primitive_c = 1'b0;
    case (rec.value_type)
      VT_KEYWORD, VT_LENGTH, VT_NUMBER, VT_COLOR, VT_PERCENT, VT_INITIAL:
        is_primitive_c = 1'b1;
      default: ;
    endcase
    is_valid_display_c = (rec.prop_id == DISPLAY_PROP_ID) &&
                         (((rec.value_type == VT_KEYWORD) &&
                           (rec.value < VAL_W'(N_DISPLAY_KW))) ||
                          (rec.value_type == VT_INITIAL));
  end

endmodule

// File: rtl/display_decl_classifier.sv
// Accepts CSS declarations, resolves INHERIT via a parent fetch, and emits a
// one-cycle qualified display record for the downstream load register.
module display_decl_classifier
  import display_pkg::*;
#(
  parameter logic [PROP_W-1:0] DISPLAY_PROP_ID = DEFAULT_DISPLAY_PROP_ID,
  parameter int unsigned       N_DISPLAY_KW    = 20,
  parameter int unsigned       TIMEOUT         = 64
) (
  input  logic                        clock,
  input  logic                        reset_n,
  display_decl_classifier_if.slave    bus,
  output logic                        out_strobe,
  output logic                        is_primitive_value,
  output logic                        is_valid_display_value,
  output logic [REC_W-1:0]            display_value,
  output logic                        inherit_timeout,
  output logic [15:0]                 load_count
);

  localparam int unsigned TMR_W = 8;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q;
  logic [PROP_W-1:0]  prop_q;
  logic               accept_c, timeout_c, is_inherit_c;
  logic               strobe_d, ready_d, req_d;
  display_rec_t       cand_c;
  logic               cand_prim_c, cand_valid_c;
  logic               unused_parent_prop;

  // Parent prop_id is replaced by the registered one, so its bits are dropped.
  assign unused_parent_prop = ^bus.parent_value[PROP_MSB:TYPE_MSB+1];

  assign accept_c     = (state_q == ST_IDLE) && bus.decl_valid && bus.decl_ready;
  assign is_inherit_c = (bus.decl_value_type == VT_INHERIT);
  assign timeout_c    = (state_q == ST_FETCH) && !bus.parent_ack &&
                        (timer_q == TMR_W'(TIMEOUT - 1));

  // State register and fetch bookkeeping
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      prop_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept_c) begin
        timer_q <= '0;
        prop_q  <= bus.decl_prop_id;
      end else if (state_q == ST_FETCH) begin
        timer_q <= timer_q + TMR_W'(1);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept_c) state_d = is_inherit_c ? ST_FETCH : ST_EMIT;
      ST_FETCH: if (bus.parent_ack || timeout_c) state_d = ST_EMIT;
      ST_EMIT:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode: candidate record and next values of the registered outputs
  always_comb begin
    cand_c   = '0;
    strobe_d = (state_d == ST_EMIT);
    ready_d  = (state_d == ST_IDLE);
    req_d    = (state_d == ST_FETCH);
    if (state_q == ST_IDLE) begin
      cand_c.prop_id    = bus.decl_prop_id;
      cand_c.value_type = bus.decl_value_type;
      cand_c.value      = bus.decl_value;
    end else if (state_q == ST_FETCH) begin
      cand_c.prop_id = prop_q;
      if (bus.parent_ack) begin
        cand_c.value_type = bus.parent_value[TYPE_MSB:VAL_MSB+1];
        cand_c.value      = bus.parent_value[VAL_MSB:0];
      end else begin
        cand_c.value_type = VT_INITIAL;
        cand_c.value      = '0;
      end
    end
  end

  display_decl_classify #(
    .DISPLAY_PROP_ID (DISPLAY_PROP_ID),
    .N_DISPLAY_KW    (N_DISPLAY_KW)
  ) u_classify (
    .rec                (cand_c),
    .is_primitive_c     (cand_prim_c),
    .is_valid_display_c (cand_valid_c)
  );

  // Registered outputs; qualifiers are forced low outside the strobe cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_strobe             <= 1'b0;
      is_primitive_value     <= 1'b0;
      is_valid_display_value <= 1'b0;
      display_value          <= '0;
      inherit_timeout        <= 1'b0;
      load_count             <= '0;
      bus.decl_ready         <= 1'b0;
      bus.parent_req         <= 1'b0;
    end else begin
      out_strobe             <= strobe_d;
      is_primitive_value     <= strobe_d && cand_prim_c;
      is_valid_display_value <= strobe_d && cand_valid_c;
      inherit_timeout        <= timeout_c;
      bus.decl_ready         <= ready_d;
      bus.parent_req         <= req_d;
      if (strobe_d) display_value <= cand_c;
      if (strobe_d && cand_prim_c && cand_valid_c && (load_count != 16'hFFFF))
        load_count <= load_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_display_decl_classifier.sv
// Self-checking bench: vector table plus scoreboard of expected strobes.
module tb_display_decl_classifier;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        out_strobe, is_primitive_value, is_valid_display_value, inherit_timeout;
  logic [58:0] display_value;
  logic [15:0] load_count;

  display_decl_classifier_if bus ();

  display_decl_classifier dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .bus                    (bus),
    .out_strobe             (out_strobe),
    .is_primitive_value     (is_primitive_value),
    .is_valid_display_value (is_valid_display_value),
    .display_value          (display_value),
    .inherit_timeout        (inherit_timeout),
    .load_count             (load_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  prop;
    logic [3:0]  vtype;
    logic [46:0] value;
    logic        prim;
    logic        valid;
  } vec_t;

  typedef struct {
    logic [58:0] rec;
    logic        prim;
    logic        valid;
    logic        tmo;
    logic [15:0] lc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   strobes_seen = 0;
  int   strobes_exp = 0;
  logic [15:0] model_lc = 16'd0;
  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [58:0] rec, input logic prim, input logic valid,
                          input logic tmo);
    exp_t e;
    if (prim && valid && model_lc != 16'hFFFF) model_lc = model_lc + 16'd1;
    e.rec = rec; e.prim = prim; e.valid = valid; e.tmo = tmo; e.lc = model_lc;
    exp_q.push_back(e);
    strobes_exp++;
  endtask

  // Offer one declaration and return #1 after the accepting edge.
  task automatic send(input logic [7:0] p, input logic [3:0] t, input logic [46:0] v);
    int n = 0;
    bus.decl_valid = 1'b1; bus.decl_prop_id = p; bus.decl_value_type = t; bus.decl_value = v;
    while (!bus.decl_ready && n < 20) begin @(posedge clock); #1; n++; end
    if (!bus.decl_ready) check("ready_wait", 64'(bus.decl_ready), 64'd1);
    @(posedge clock); #1;
    bus.decl_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // Scoreboard pop and strobe-cycle rules
  always @(negedge clock) begin
    if (reset_n) begin
      if (out_strobe) begin
        strobes_seen++;
        check("ready_low_in_emit", 64'(bus.decl_ready), 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 64'(out_strobe), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("display_value", 64'(display_value), 64'(e.rec));
          check("is_primitive", 64'(is_primitive_value), 64'(e.prim));
          check("is_valid_display", 64'(is_valid_display_value), 64'(e.valid));
          check("inherit_timeout", 64'(inherit_timeout), 64'(e.tmo));
          check("load_count", 64'(load_count), 64'(e.lc));
        end
      end else begin
        check("quals_low_no_strobe",
              64'({is_primitive_value, is_valid_display_value, inherit_timeout}), 64'd0);
      end
    end
  end

  initial begin
    int cnt;
    int k;
    logic r;
    vecs[0]  = '{8'h1D, 4'd0, 47'd3,  1'b1, 1'b1};
    vecs[1]  = '{8'h1D, 4'd0, 47'd20, 1'b1, 1'b0};
    vecs[2]  = '{8'h22, 4'd1, 47'd16, 1'b1, 1'b0};
    vecs[3]  = '{8'h1D, 4'd0, 47'd19, 1'b1, 1'b1};
    vecs[4]  = '{8'h1D, 4'd8, 47'd0,  1'b1, 1'b1};
    vecs[5]  = '{8'h1D, 4'd5, 47'd5,  1'b0, 1'b0};
    vecs[6]  = '{8'h1D, 4'd6, 47'd1,  1'b0, 1'b0};
    vecs[7]  = '{8'h1D, 4'd12, 47'd0, 1'b0, 1'b0};
    vecs[8]  = '{8'h1E, 4'd0, 47'd3,  1'b1, 1'b0};
    vecs[9]  = '{8'h1D, 4'd2, 47'd3,  1'b1, 1'b0};
    vecs[10] = '{8'h22, 4'd3, 47'h123456, 1'b1, 1'b0};
    vecs[11] = '{8'h1D, 4'd4, 47'd50, 1'b1, 1'b0};

    bus.decl_valid = 1'b0; bus.decl_prop_id = '0; bus.decl_value_type = '0;
    bus.decl_value = '0; bus.parent_ack = 1'b0; bus.parent_value = '0;

    // Reset state
    #12;
    check("rst_ready", 64'(bus.decl_ready), 64'd0);
    check("rst_outputs", 64'({out_strobe, is_primitive_value, is_valid_display_value,
                               inherit_timeout, bus.parent_req}), 64'd0);
    check("rst_display_value", 64'(display_value), 64'd0);
    check("rst_load_count", 64'(load_count), 64'd0);
    @(negedge clock); reset_n = 1'b1;
    tick();
    check("ready_after_release", 64'(bus.decl_ready), 64'd1);

    // Table-driven single declarations, strobe one cycle after accept
    for (int i = 0; i < 12; i++) begin
      push_exp({vecs[i].prop, vecs[i].vtype, vecs[i].value}, vecs[i].prim, vecs[i].valid, 1'b0);
      send(vecs[i].prop, vecs[i].vtype, vecs[i].value);
      check("strobe_latency", 64'(out_strobe), 64'd1);
      if (i == 0) check("first_load_count", 64'(load_count), 64'd1);
    end
    tick();
    check("ready_two_after_accept", 64'(bus.decl_ready), 64'd1);

    // INHERIT resolved by ack in the fifth FETCH cycle
    push_exp({8'h1D, 4'd0, 47'd2}, 1'b1, 1'b1, 1'b0);
    send(8'h1D, 4'd7, 47'd0);
    for (int i = 0; i < 5; i++) begin
      check("fetch_req_high", 64'(bus.parent_req), 64'd1);
      if (i == 4) begin bus.parent_ack = 1'b1; bus.parent_value = {8'hAB, 4'd0, 47'd2}; end
      tick();
    end
    bus.parent_ack = 1'b0;
    check("ack_strobe", 64'(out_strobe), 64'd1);
    check("ack_req_dropped", 64'(bus.parent_req), 64'd0);
    tick();

    // INHERIT with no ack: 64 request cycles then INITIAL with timeout pulse
    push_exp({8'h1D, 4'd8, 47'd0}, 1'b1, 1'b1, 1'b1);
    send(8'h1D, 4'd7, 47'd9);
    cnt = 0;
    while (bus.parent_req && cnt < 300) begin cnt++; tick(); end
    check("timeout_req_cycles", 64'(cnt), 64'd64);
    check("timeout_strobe", 64'(out_strobe), 64'd1);
    check("timeout_pulse", 64'(inherit_timeout), 64'd1);
    tick();
    check("timeout_pulse_single", 64'(inherit_timeout), 64'd0);

    // Ack arriving on the timeout cycle wins
    push_exp({8'h1D, 4'd1, 47'd16}, 1'b1, 1'b0, 1'b0);
    send(8'h1D, 4'd7, 47'd0);
    for (int i = 0; i < 64; i++) begin
      if (i == 63) begin bus.parent_ack = 1'b1; bus.parent_value = {8'h00, 4'd1, 47'd16}; end
      tick();
    end
    bus.parent_ack = 1'b0;
    check("late_ack_strobe", 64'(out_strobe), 64'd1);
    tick();

    // parent_ack outside FETCH has no effect
    bus.parent_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_ack_no_req", 64'(bus.parent_req), 64'd0);
    end
    bus.parent_ack = 1'b0;

    // decl_valid held high across four declarations
    k = 0; cnt = 0;
    bus.decl_valid = 1'b1;
    bus.decl_prop_id = vecs[0].prop; bus.decl_value_type = vecs[0].vtype;
    bus.decl_value = vecs[0].value;
    while (k < 4 && cnt < 40) begin
      r = bus.decl_ready;
      if (r) push_exp({vecs[k].prop, vecs[k].vtype, vecs[k].value}, vecs[k].prim, vecs[k].valid, 1'b0);
      tick();
      if (r) begin
        k++;
        if (k < 4) begin
          bus.decl_prop_id = vecs[k].prop; bus.decl_value_type = vecs[k].vtype;
          bus.decl_value = vecs[k].value;
        end else begin
          bus.decl_valid = 1'b0;
        end
      end
      cnt++;
    end
    check("b2b_cycles", 64'(cnt), 64'd7);
    tick(); tick();

    // Reset asserted mid-FETCH discards the pending declaration
    send(8'h1D, 4'd7, 47'd0);
    tick(); tick();
    check("pre_reset_req", 64'(bus.parent_req), 64'd1);
    reset_n = 1'b0;
    #1;
    check("async_req_drop", 64'(bus.parent_req), 64'd0);
    check("async_outputs", 64'({out_strobe, bus.decl_ready, inherit_timeout}), 64'd0);
    check("async_load_count", 64'(load_count), 64'd0);
    model_lc = 16'd0;
    tick(); tick();
    @(negedge clock); reset_n = 1'b1;
    tick();
    check("ready_after_midfetch_reset", 64'(bus.decl_ready), 64'd1);
    for (int i = 0; i < 4; i++) tick();

    // FUNCTION after reset: no load
    push_exp({8'h1D, 4'd5, 47'd3}, 1'b0, 1'b0, 1'b0);
    send(8'h1D, 4'd5, 47'd3);
    check("func_strobe", 64'(out_strobe), 64'd1);
    for (int i = 0; i < 4; i++) tick();

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("strobe_total", 64'(strobes_seen), 64'(strobes_exp));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
